// File: rtl/aes_256_key_store.sv
// AES-256 round-key store: expands the cipher key once into 60 words, then
// serves 128-bit round keys by index in forward or reversed order.
//
// state  | meaning
// IDLE   | no valid schedule since reset
// EXPAND | generating w[8..59], two cycles per word through the shared S-box
// READY  | complete schedule held, reads enabled

module aes_256_key_store (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] key_in,
    input  logic         key_load,
    input  logic         enc_en,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_out,
    output logic         busy,
    output logic         key_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [5:0]  word_idx;
    logic [5:0]  word_idx_nxt;
    logic        phase;
    logic        phase_nxt;
    logic        word_we;

    logic [31:0] w [60];
    logic [31:0] w_prev;
    logic [31:0] w_back8;
    logic [31:0] sbox_in;
    logic [31:0] sbox_q;
    logic [31:0] t_word;
    logic [31:0] new_word;
    logic [7:0]  rcon;

    logic [3:0]  eff_idx;
    logic [5:0]  rd_base;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        logic [7:0] bb;
        acc = 8'h00;
        aa  = a;
        bb  = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) acc = acc ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = {1'b0, bb[7:1]};
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0), followed by the affine map.
    function automatic logic [7:0] sbox_byte(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    assign busy      = (state == EXPAND);
    assign key_ready = (state == READY);

    assign w_prev  = w[word_idx - 6'd1];
    assign w_back8 = w[word_idx - 6'd8];
    assign sbox_in = (word_idx[2:0] == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    assign rcon    = 8'h01 << (word_idx[5:3] - 3'd1);

    always_comb begin
        t_word = w_prev;
        case (word_idx[2:0])
            3'd0:    t_word = sbox_q ^ {rcon, 24'h000000};
            3'd4:    t_word = sbox_q;
            default: t_word = w_prev;
        endcase
    end

    assign new_word = w_back8 ^ t_word;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            word_idx <= 6'd0;
            phase    <= 1'b0;
        end else begin
            state    <= state_nxt;
            word_idx <= word_idx_nxt;
            phase    <= phase_nxt;
        end
    end

    // A load always wins, including over the final word write.
    always_comb begin
        state_nxt    = state;
        word_idx_nxt = word_idx;
        phase_nxt    = phase;
        word_we      = 1'b0;
        if (key_load) begin
            state_nxt    = EXPAND;
            word_idx_nxt = 6'd8;
            phase_nxt    = 1'b0;
        end else if (state == EXPAND) begin
            if (!phase) begin
                phase_nxt = 1'b1;
            end else begin
                word_we      = 1'b1;
                phase_nxt    = 1'b0;
                word_idx_nxt = word_idx + 6'd1;
                if (word_idx == 6'd59) state_nxt = READY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sbox_q <= 32'h0;
        end else if (state == EXPAND && !phase) begin
            sbox_q <= {sbox_byte(sbox_in[31:24]), sbox_byte(sbox_in[23:16]),
                       sbox_byte(sbox_in[15:8]),  sbox_byte(sbox_in[7:0])};
        end
    end

    // Word store is deliberately unreset; READY gates every read of it.
    always_ff @(posedge clk) begin
        if (key_load) begin
            w[0] <= key_in[255:224];
            w[1] <= key_in[223:192];
            w[2] <= key_in[191:160];
            w[3] <= key_in[159:128];
            w[4] <= key_in[127:96];
            w[5] <= key_in[95:64];
            w[6] <= key_in[63:32];
            w[7] <= key_in[31:0];
        end else if (word_we) begin
            w[word_idx] <= new_word;
        end
    end

    assign eff_idx = enc_en ? rk_idx : (4'd14 - rk_idx);
    assign rd_base = {eff_idx, 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rk_out <= 128'h0;
        end else if (state == READY && rk_idx <= 4'd14) begin
            rk_out <= {w[rd_base], w[rd_base + 6'd1], w[rd_base + 6'd2], w[rd_base + 6'd3]};
        end else begin
            rk_out <= 128'h0;
        end
    end

endmodule

// File: tb/tb_aes_256_key_store.sv
// Scoreboard bench for aes_256_key_store: a driver issues per-cycle reads and
// loads while a negedge monitor compares outputs against a FIPS-style model.

module tb_aes_256_key_store;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] key_in;
    logic         key_load;
    logic         enc_en;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;
    logic         busy;
    logic         key_ready;

    aes_256_key_store dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_load  (key_load),
        .enc_en    (enc_en),
        .rk_idx    (rk_idx),
        .rk_out    (rk_out),
        .busy      (busy),
        .key_ready (key_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int           at;
        logic [127:0] rk;
        logic         bsy;
        logic         rdy;
        int           tag;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   tag_n  = 0;

    logic [7:0]  sbox_t [256];
    logic [31:0] cur_w  [60];
    logic [31:0] pend_w [60];
    bit          m_ready;
    bit          m_exp;
    int          m_cnt;

    task automatic cmp(input string name, input int tag, input logic [127:0] act,
                       input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s tag=%0d actual=%h required=%h", name, tag, act, req);
        end
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.at < cyc) begin
                checks++;
                errors++;
                $display("FAIL sb_stale tag=%0d actual=cycle %0d required=cycle %0d", e.tag, cyc, e.at);
            end else begin
                cmp("rk_out", e.tag, rk_out, e.rk);
                cmp("busy", e.tag, {127'h0, busy}, {127'h0, e.bsy});
                cmp("key_ready", e.tag, {127'h0, key_ready}, {127'h0, e.rdy});
            end
        end
    end

    function automatic int gmul(input int a, input int b);
        int p = 0;
        int x = a;
        int y = b;
        while (y != 0) begin
            if ((y & 1) != 0) p = p ^ x;
            x = x << 1;
            if ((x & 256) != 0) x = x ^ 'h11b;
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            int inv = 0;
            int s   = 0;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (gmul(x, y) == 1) inv = y;
            for (int i = 0; i < 8; i++) begin
                int bitv;
                bitv = ((inv >> i) & 1) ^ ((inv >> ((i + 4) % 8)) & 1) ^ ((inv >> ((i + 5) % 8)) & 1)
                     ^ ((inv >> ((i + 6) % 8)) & 1) ^ ((inv >> ((i + 7) % 8)) & 1) ^ (('h63 >> i) & 1);
                s = s | (bitv << i);
            end
            sbox_t[x] = 8'(s);
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] v);
        return {sbox_t[v[31:24]], sbox_t[v[23:16]], sbox_t[v[15:8]], sbox_t[v[7:0]]};
    endfunction

    task automatic expand_key(input logic [255:0] k);
        for (int i = 0; i < 8; i++) pend_w[i] = k[255 - 32 * i -: 32];
        for (int i = 8; i < 60; i++) begin
            logic [31:0] t;
            t = pend_w[i - 1];
            if (i % 8 == 0)
                t = sub_word({t[23:0], t[31:24]}) ^ (32'(1 << (i / 8 - 1)) << 24);
            else if (i % 8 == 4)
                t = sub_word(t);
            pend_w[i] = pend_w[i - 8] ^ t;
        end
    endtask

    // One driven cycle: inputs set at a negedge, sampled at the next posedge.
    task automatic step(input logic [3:0] idx, input bit enc, input bit load,
                        input logic [255:0] key, input bit use_fixed, input logic [127:0] fixed);
        exp_t e;
        int   ei;
        rk_idx   = idx;
        enc_en   = enc;
        key_load = load;
        key_in   = key;
        e.rk = 128'h0;
        if (m_ready && idx <= 14) begin
            ei   = enc ? int'(idx) : 14 - int'(idx);
            e.rk = {cur_w[4 * ei], cur_w[4 * ei + 1], cur_w[4 * ei + 2], cur_w[4 * ei + 3]};
        end
        if (use_fixed) e.rk = fixed;
        if (load) begin
            expand_key(key);
            m_exp   = 1'b1;
            m_ready = 1'b0;
            m_cnt   = 104;
        end else if (m_exp) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_exp   = 1'b0;
                m_ready = 1'b1;
                cur_w   = pend_w;
            end
        end
        e.at  = cyc + 1;
        e.bsy = m_exp;
        e.rdy = m_ready;
        e.tag = tag_n++;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle_steps(input int n);
        for (int k = 0; k < n; k++)
            step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0, 256'h0, 1'b0, 128'h0);
    endtask

    task automatic load_key(input logic [255:0] k);
        step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1, k, 1'b0, 128'h0);
    endtask

    task automatic rd(input logic [3:0] idx, input bit enc);
        step(idx, enc, 1'b0, 256'h0, 1'b0, 128'h0);
    endtask

    task automatic rd_fixed(input logic [3:0] idx, input bit enc, input logic [127:0] v);
        step(idx, enc, 1'b0, 256'h0, 1'b1, v);
    endtask

    // Reset pulsed inside the low clock phase; outputs must clear with no edge.
    task automatic async_reset(input int tag);
        #1 rst = 1'b0;
        #1;
        cmp("rst_busy", tag, {127'h0, busy}, 128'h0);
        cmp("rst_key_ready", tag, {127'h0, key_ready}, 128'h0);
        cmp("rst_rk_out", tag, rk_out, 128'h0);
        m_ready = 1'b0;
        m_exp   = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [255:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    localparam logic [255:0] KV = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    initial begin
        rst      = 1'b0;
        key_in   = 256'h0;
        key_load = 1'b0;
        enc_en   = 1'b1;
        rk_idx   = 4'd0;
        m_ready  = 1'b0;
        m_exp    = 1'b0;
        m_cnt    = 0;
        build_sbox();
        #3;
        cmp("reset_rk_out", -1, rk_out, 128'h0);
        cmp("reset_busy", -1, {127'h0, busy}, 128'h0);
        cmp("reset_key_ready", -1, {127'h0, key_ready}, 128'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Known vector, forward and reversed order, out-of-range index.
        load_key(KV);
        idle_steps(104);
        rd_fixed(4'd1, 1'b1, 128'h101112131415161718191a1b1c1d1e1f);
        rd_fixed(4'd2, 1'b1, 128'ha573c29fa176c498a97fce93a572c09c);
        rd_fixed(4'd14, 1'b1, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        rd_fixed(4'd0, 1'b0, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        rd_fixed(4'd14, 1'b0, 128'h000102030405060708090a0b0c0d0e0f);
        rd_fixed(4'd0, 1'b1, 128'h000102030405060708090a0b0c0d0e0f);
        rd_fixed(4'd15, 1'b1, 128'h0);
        rd_fixed(4'd15, 1'b0, 128'h0);

        // Reload in the middle of an expansion with the all-zero key.
        load_key(rand_key());
        idle_steps(49);
        load_key(256'h0);
        idle_steps(104);
        rd(4'd14, 1'b1);
        rd(4'd0, 1'b0);
        rd(4'd7, 1'b1);

        // Load coinciding with the final word write.
        load_key(rand_key());
        idle_steps(103);
        load_key(KV);
        idle_steps(104);
        rd_fixed(4'd2, 1'b1, 128'ha573c29fa176c498a97fce93a572c09c);

        // Reset during an expansion, then idle with no load, then a fresh load.
        load_key(rand_key());
        idle_steps(29);
        async_reset(1000);
        idle_steps(120);
        load_key(KV);
        idle_steps(104);
        rd_fixed(4'd14, 1'b1, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        rd(4'd5, 1'b0);
        async_reset(1001);
        idle_steps(3);

        // Random keys, every (index, order) pair read back.
        for (int n = 0; n < 200; n++) begin
            load_key(rand_key());
            idle_steps(104);
            for (int enc = 0; enc < 2; enc++)
                for (int idx = 0; idx < 15; idx++)
                    rd(4'(idx), 1'(enc));
        end
        idle_steps(2);

        @(negedge clk);
        cmp("sb_drained", -1, 128'(sb_q.size()), 128'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
